// File: rtl/v_tbl_sched.sv
// Context-state table controller: runs the init sweep, arbitrates the single SRAM
// read port between the update and query pipes, and forwards same-cycle write data.
module v_tbl_sched #(
  parameter int            N          = 16,
  parameter int            W          = 64,
  parameter logic [W-1:0]  INIT_VAL   = '0,
  parameter int            STARVE_MAX = 4,
  localparam int           AW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_reinit,
  input  logic          i_upd_ren,
  input  logic [AW-1:0] i_upd_raddr,
  output logic          o_upd_rgnt,
  input  logic          i_qry_ren,
  input  logic [AW-1:0] i_qry_raddr,
  output logic          o_qry_rgnt,
  input  logic          i_upd_wen,
  input  logic [AW-1:0] i_upd_waddr,
  input  logic [W-1:0]  i_upd_wdata,
  output logic          o_sram_ren,
  output logic [AW-1:0] o_sram_raddr,
  input  logic [W-1:0]  i_sram_rdata,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_waddr,
  output logic [W-1:0]  o_sram_wdata,
  output logic          o_rd_vld_r,
  output logic          o_rd_id_r,
  output logic [W-1:0]  o_rd_data,
  output logic          o_busy_r,
  output logic          o_err_r
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      starve_reg, starve_next;
  logic            fwd_reg;
  logic [W-1:0]    fwd_data_reg;

  logic            run;
  logic            sweep_wen;
  logic            pipe_wen;
  logic            qry_force;
  logic            upd_gnt;
  logic            qry_gnt;
  logic            rd_gnt;
  logic [AW-1:0]   rd_addr;
  logic            fwd_hit;

  // Next-state and sweep address counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + AW'(1);
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (i_reinit) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Sweep writes are held off while reset is asserted, even though the state is INIT.
  always_comb begin
    run       = (state_reg == ST_RUN);
    sweep_wen = (state_reg == ST_INIT) && rst;
    pipe_wen  = run && i_upd_wen;

    qry_force = i_qry_ren && (starve_reg == STARVE_LIM);
    upd_gnt   = run && i_upd_ren && !qry_force;
    qry_gnt   = run && i_qry_ren && !upd_gnt;
    rd_gnt    = upd_gnt || qry_gnt;
    rd_addr   = qry_gnt ? i_qry_raddr : i_upd_raddr;

    fwd_hit   = rd_gnt && pipe_wen && (i_upd_waddr == rd_addr);

    starve_next = starve_reg;
    if (!i_qry_ren || qry_gnt) begin
      starve_next = '0;
    end else if (run && (starve_reg != STARVE_LIM)) begin
      starve_next = starve_reg + 4'd1;
    end
  end

  assign o_upd_rgnt   = upd_gnt;
  assign o_qry_rgnt   = qry_gnt;
  assign o_sram_ren   = rd_gnt;
  assign o_sram_raddr = rd_addr;
  assign o_sram_wen   = sweep_wen || pipe_wen;
  assign o_sram_waddr = sweep_wen ? cnt_reg  : i_upd_waddr;
  assign o_sram_wdata = sweep_wen ? INIT_VAL : i_upd_wdata;
  assign o_rd_data    = fwd_reg ? fwd_data_reg : i_sram_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_INIT;
      cnt_reg    <= '0;
      starve_reg <= '0;
      fwd_reg    <= 1'b0;
      o_busy_r   <= 1'b1;
      o_rd_vld_r <= 1'b0;
      o_rd_id_r  <= 1'b0;
      o_err_r    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      starve_reg <= starve_next;
      fwd_reg    <= fwd_hit;
      o_busy_r   <= (state_next != ST_RUN);
      o_rd_vld_r <= rd_gnt;
      o_rd_id_r  <= qry_gnt;
      if (i_upd_wen && o_busy_r) begin
        o_err_r <= 1'b1;
      end
    end
  end

  // Pure data register; only meaningful while fwd_reg is set.
  always_ff @(posedge clk) begin
    if (fwd_hit) begin
      fwd_data_reg <= i_upd_wdata;
    end
  end

endmodule

// File: tb/tb_v_tbl_sched.sv
// Bench for v_tbl_sched: SRAM model on the memory ports, reference table and a
// result scoreboard filled when grants are observed and drained when results return.
`timescale 1ns/1ps
module tb_v_tbl_sched;
  localparam int N  = 16;
  localparam int W  = 64;
  localparam int AW = 4;
  localparam int SM = 4;
  localparam logic [W-1:0] IV = 64'hC0DE_0000_5A5A_0001;

  logic          clk;
  logic          rst;
  logic          i_reinit;
  logic          i_upd_ren;
  logic [AW-1:0] i_upd_raddr;
  logic          o_upd_rgnt;
  logic          i_qry_ren;
  logic [AW-1:0] i_qry_raddr;
  logic          o_qry_rgnt;
  logic          i_upd_wen;
  logic [AW-1:0] i_upd_waddr;
  logic [W-1:0]  i_upd_wdata;
  logic          o_sram_ren;
  logic [AW-1:0] o_sram_raddr;
  logic [W-1:0]  sram_rdata;
  logic          o_sram_wen;
  logic [AW-1:0] o_sram_waddr;
  logic [W-1:0]  o_sram_wdata;
  logic          o_rd_vld_r;
  logic          o_rd_id_r;
  logic [W-1:0]  o_rd_data;
  logic          o_busy_r;
  logic          o_err_r;

  v_tbl_sched #(.N(N), .W(W), .INIT_VAL(IV), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .i_reinit(i_reinit),
    .i_upd_ren(i_upd_ren), .i_upd_raddr(i_upd_raddr), .o_upd_rgnt(o_upd_rgnt),
    .i_qry_ren(i_qry_ren), .i_qry_raddr(i_qry_raddr), .o_qry_rgnt(o_qry_rgnt),
    .i_upd_wen(i_upd_wen), .i_upd_waddr(i_upd_waddr), .i_upd_wdata(i_upd_wdata),
    .o_sram_ren(o_sram_ren), .o_sram_raddr(o_sram_raddr), .i_sram_rdata(sram_rdata),
    .o_sram_wen(o_sram_wen), .o_sram_waddr(o_sram_waddr), .o_sram_wdata(o_sram_wdata),
    .o_rd_vld_r(o_rd_vld_r), .o_rd_id_r(o_rd_id_r), .o_rd_data(o_rd_data),
    .o_busy_r(o_busy_r), .o_err_r(o_err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1R1W SRAM, registered read returning the old contents on a same-address write.
  logic [W-1:0] sram_mem [N];
  always @(posedge clk) begin
    if (o_sram_ren) sram_rdata <= sram_mem[o_sram_raddr];
    if (o_sram_wen) sram_mem[o_sram_waddr] <= o_sram_wdata;
  end

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] ref_mem [N];
  int           n_cmp = 0;
  int           n_bad = 0;

  always begin : result_monitor
    exp_t e;
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (o_rd_vld_r !== 1'b1 || o_rd_id_r !== e.id || o_rd_data !== e.data) begin
        n_bad++;
        $display("FAIL rd_result t=%0t: vld=%b id=%b data=%h, required vld=1 id=%b data=%h",
                 $time, o_rd_vld_r, o_rd_id_r, o_rd_data, e.id, e.data);
      end
    end else if (o_rd_vld_r !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_spurious t=%0t: vld=%b, required vld=0", $time, o_rd_vld_r);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    i_reinit = 0; i_upd_ren = 0; i_upd_raddr = '0; i_qry_ren = 0; i_qry_raddr = '0;
    i_upd_wen = 0; i_upd_waddr = '0; i_upd_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    i_upd_ren = 1; i_qry_ren = 1; i_upd_wen = 1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b1 || o_rd_vld_r !== 1'b0 || o_rd_id_r !== 1'b0 || o_err_r !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_regs: busy=%b vld=%b id=%b err=%b, required 1 0 0 0",
               o_busy_r, o_rd_vld_r, o_rd_id_r, o_err_r);
    end
    n_cmp++;
    if (o_sram_wen !== 1'b0 || o_sram_ren !== 1'b0 || o_upd_rgnt !== 1'b0 || o_qry_rgnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ports: wen=%b ren=%b ug=%b qg=%b, required all 0",
               o_sram_wen, o_sram_ren, o_upd_rgnt, o_qry_rgnt);
    end
    idle();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_cmp++;
      if (o_sram_wen !== 1'b1 || o_sram_waddr !== AW'(i) || o_sram_wdata !== IV || o_busy_r !== 1'b1) begin
        n_bad++;
        $display("FAIL init_sweep[%0d]: wen=%b addr=%0d data=%h busy=%b, required 1 %0d %h 1",
                 i, o_sram_wen, o_sram_waddr, o_sram_wdata, o_busy_r, i, IV);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b0 || o_sram_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL init_done: busy=%b wen=%b, required 0 0", o_busy_r, o_sram_wen);
    end
    for (int i = 0; i < N; i++) ref_mem[i] = IV;
  endtask

  task automatic test_write_read();
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      idle();
      i_upd_wen = 1; i_upd_waddr = AW'(i); i_upd_wdata = {$urandom, $urandom};
      #1;
      ref_mem[i] = i_upd_wdata;
      n_cmp++;
      if (o_sram_wen !== 1'b1 || o_sram_waddr !== AW'(i) || o_sram_wdata !== i_upd_wdata) begin
        n_bad++;
        $display("FAIL write_pass[%0d]: wen=%b addr=%0d data=%h, required 1 %0d %h",
                 i, o_sram_wen, o_sram_waddr, o_sram_wdata, i, i_upd_wdata);
      end
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      idle();
      if (i % 2 == 0) begin a = AW'(i); i_upd_ren = 1; i_upd_raddr = a; end
      else begin a = AW'(N - 1 - i); i_qry_ren = 1; i_qry_raddr = a; end
      #1;
      n_cmp++;
      if (o_upd_rgnt !== (i % 2 == 0) || o_qry_rgnt !== (i % 2 == 1) ||
          o_sram_ren !== 1'b1 || o_sram_raddr !== a) begin
        n_bad++;
        $display("FAIL single_read[%0d]: ug=%b qg=%b ren=%b addr=%0d, required ug=%b qg=%b ren=1 addr=%0d",
                 i, o_upd_rgnt, o_qry_rgnt, o_sram_ren, o_sram_raddr, (i % 2 == 0), (i % 2 == 1), a);
      end
      sb_q.push_back('{id: (i % 2 == 1), data: ref_mem[a]});
    end
    @(negedge clk);
    idle();
  endtask

  // Both pipes request every cycle; query must win every (STARVE_MAX+1)-th cycle.
  task automatic test_arbitration();
    int            sc = 0;
    logic          eq;
    logic [AW-1:0] au = 0, aq = 8;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      i_upd_ren = 1; i_upd_raddr = au; i_qry_ren = 1; i_qry_raddr = aq;
      #1;
      eq = (sc == SM);
      n_cmp++;
      if (o_upd_rgnt !== !eq || o_qry_rgnt !== eq || o_sram_raddr !== (eq ? aq : au)) begin
        n_bad++;
        $display("FAIL arb[%0d]: ug=%b qg=%b addr=%0d, required ug=%b qg=%b addr=%0d",
                 c, o_upd_rgnt, o_qry_rgnt, o_sram_raddr, !eq, eq, eq ? aq : au);
      end
      sb_q.push_back('{id: eq, data: ref_mem[eq ? aq : au]});
      if (eq) begin sc = 0; aq = aq + 1; end
      else begin sc = (sc < SM) ? sc + 1 : sc; au = au + 1; end
    end
    @(negedge clk);
    idle();
  endtask

  // Dropping the query request must clear the starvation count.
  task automatic test_starve_clear();
    logic [8:0]    qpat = 9'b111110111;
    int            sc = 0;
    logic          qr, eu, eq;
    logic [AW-1:0] au = 2, aq = 12;
    for (int c = 0; c < 9; c++) begin
      qr = qpat[c];
      @(negedge clk);
      i_upd_ren = 1; i_upd_raddr = au; i_qry_ren = qr; i_qry_raddr = aq;
      #1;
      eu = !(qr && sc == SM);
      eq = qr && !eu;
      n_cmp++;
      if (o_upd_rgnt !== eu || o_qry_rgnt !== eq) begin
        n_bad++;
        $display("FAIL starve_clear[%0d]: ug=%b qg=%b, required ug=%b qg=%b",
                 c, o_upd_rgnt, o_qry_rgnt, eu, eq);
      end
      sb_q.push_back('{id: eq, data: ref_mem[eq ? aq : au]});
      if (!qr || eq) sc = 0;
      else if (sc < SM) sc = sc + 1;
      if (eq) aq = aq + 1; else au = au + 1;
    end
    @(negedge clk);
    idle();
  endtask

  // Each row: write (en/addr/data) and read (owner/addr) in the same cycle.
  task automatic test_forward();
    logic          wen_t [5] = '{1, 0, 1, 1, 1};
    logic [AW-1:0] wa_t  [5] = '{3, 0, 6, 6, 7};
    logic [W-1:0]  wd_t  [5] = '{64'hA5, 64'h0, 64'h1111_2222_3333_4444, 64'hBEEF_0000_CAFE_0006, 64'h77};
    logic          qry_t [5] = '{0, 0, 1, 1, 0};
    logic [AW-1:0] ra_t  [5] = '{3, 3, 5, 6, 6};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle();
      i_upd_wen = wen_t[c]; i_upd_waddr = wa_t[c]; i_upd_wdata = wd_t[c];
      if (qry_t[c]) begin i_qry_ren = 1; i_qry_raddr = ra_t[c]; end
      else begin i_upd_ren = 1; i_upd_raddr = ra_t[c]; end
      #1;
      if (wen_t[c]) ref_mem[wa_t[c]] = wd_t[c];
      n_cmp++;
      if (o_upd_rgnt !== !qry_t[c] || o_qry_rgnt !== qry_t[c] || o_sram_wen !== wen_t[c]) begin
        n_bad++;
        $display("FAIL fwd_cycle[%0d]: ug=%b qg=%b wen=%b, required ug=%b qg=%b wen=%b",
                 c, o_upd_rgnt, o_qry_rgnt, o_sram_wen, !qry_t[c], qry_t[c], wen_t[c]);
      end
      sb_q.push_back('{id: qry_t[c], data: ref_mem[ra_t[c]]});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reinit();
    @(negedge clk);
    i_upd_ren = 1; i_upd_raddr = 9; i_reinit = 1;
    #1;
    n_cmp++;
    if (o_upd_rgnt !== 1'b1) begin
      n_bad++;
      $display("FAIL reinit_grant: ug=%b, required 1", o_upd_rgnt);
    end
    sb_q.push_back('{id: 1'b0, data: ref_mem[9]});
    @(negedge clk);
    i_reinit = 0;
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b1 || o_rd_vld_r !== 1'b1 || o_upd_rgnt !== 1'b0 || o_sram_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: busy=%b vld=%b ug=%b wen=%b, required 1 1 0 0",
               o_busy_r, o_rd_vld_r, o_upd_rgnt, o_sram_wen);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      i_reinit = (i == 5);
      #1;
      n_cmp++;
      if (o_sram_wen !== 1'b1 || o_sram_waddr !== AW'(i) || o_sram_wdata !== IV ||
          o_busy_r !== 1'b1 || o_upd_rgnt !== 1'b0) begin
        n_bad++;
        $display("FAIL reinit_sweep[%0d]: wen=%b addr=%0d data=%h busy=%b ug=%b, required 1 %0d %h 1 0",
                 i, o_sram_wen, o_sram_waddr, o_sram_wdata, o_busy_r, o_upd_rgnt, i, IV);
      end
    end
    for (int i = 0; i < N; i++) ref_mem[i] = IV;
    @(negedge clk);
    i_reinit = 0;
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b0 || o_upd_rgnt !== 1'b1) begin
      n_bad++;
      $display("FAIL reinit_done: busy=%b ug=%b, required 0 1", o_busy_r, o_upd_rgnt);
    end
    sb_q.push_back('{id: 1'b0, data: ref_mem[9]});
    @(negedge clk);
    idle();
  endtask

  task automatic test_busy_write_err();
    @(negedge clk);
    i_reinit = 1;
    @(negedge clk);
    i_reinit = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      idle();
      if (i == 3) begin i_upd_wen = 1; i_upd_waddr = 3; i_upd_wdata = 64'h0BAD_0BAD_0BAD_0BAD; end
      #1;
      n_cmp++;
      if (o_sram_waddr !== AW'(i) || o_sram_wdata !== IV || o_err_r !== (i > 3)) begin
        n_bad++;
        $display("FAIL busy_write[%0d]: addr=%0d data=%h err=%b, required %0d %h %b",
                 i, o_sram_waddr, o_sram_wdata, o_err_r, i, IV, (i > 3));
      end
    end
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b0 || o_err_r !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: busy=%b err=%b, required 0 1", o_busy_r, o_err_r);
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk);
    i_reinit = 1;
    @(negedge clk);
    i_reinit = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (o_sram_waddr !== AW'(i)) begin
        n_bad++;
        $display("FAIL pre_reset_sweep[%0d]: addr=%0d, required %0d", i, o_sram_waddr, i);
      end
    end
    rst = 0;
    #1;
    n_cmp++;
    if (o_err_r !== 1'b0 || o_busy_r !== 1'b1 || o_sram_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: err=%b busy=%b wen=%b, required 0 1 0", o_err_r, o_busy_r, o_sram_wen);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_cmp++;
      if (o_sram_wen !== 1'b1 || o_sram_waddr !== AW'(i) || o_sram_wdata !== IV) begin
        n_bad++;
        $display("FAIL restart_sweep[%0d]: wen=%b addr=%0d data=%h, required 1 %0d %h",
                 i, o_sram_wen, o_sram_waddr, o_sram_wdata, i, IV);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (o_busy_r !== 1'b0 || o_err_r !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_done: busy=%b err=%b, required 0 0", o_busy_r, o_err_r);
    end
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_write_read();
    test_arbitration();
    test_starve_clear();
    test_forward();
    test_reinit();
    test_busy_write_err();
    test_reset_mid_sweep();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
